// File: rtl/reservation_station_pkg.sv
// Shared ALU-side definitions used by the control unit and every reservation station.
package reservation_station_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_e;

    // Index of each station's bit in the control unit's isFull vector.
    localparam int ALU_SEL_ARITH = 0;
    localparam int ALU_SEL_LOGIC = 1;
    localparam int NUM_ALU_SEL   = 2;

    // Producer tag meaning "operand value already present".
    localparam int TAG_NONE = 0;

endpackage

// File: rtl/reservation_station_rs_entry.sv
// One reservation-station slot: operand/tag storage with issue-time bypass and CDB snoop.
module rs_entry
    import reservation_station_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_i,
    input  logic              clear_i,
    input  logic [1:0]        issue_aluop_i,
    input  logic [DATA_W-1:0] issue_vj_i,
    input  logic [TAG_W-1:0]  issue_qj_i,
    input  logic [DATA_W-1:0] issue_vk_i,
    input  logic [TAG_W-1:0]  issue_qk_i,
    input  logic              cdb_valid_i,
    input  logic [TAG_W-1:0]  cdb_tag_i,
    input  logic [DATA_W-1:0] cdb_data_i,
    output logic              busy_o,
    output logic              ready_o,
    output logic [1:0]        aluop_o,
    output logic [DATA_W-1:0] vj_o,
    output logic [DATA_W-1:0] vk_o
);

    logic              busy_q, busy_d;
    logic [1:0]        aluop_q, aluop_d;
    logic [DATA_W-1:0] vj_q, vj_d, vk_q, vk_d;
    logic [TAG_W-1:0]  qj_q, qj_d, qk_q, qk_d;

    logic cdb_live, bypass_j, bypass_k, snoop_j, snoop_k;

    assign cdb_live = cdb_valid_i && (cdb_tag_i != TAG_W'(TAG_NONE));
    assign bypass_j = cdb_live && (issue_qj_i == cdb_tag_i);
    assign bypass_k = cdb_live && (issue_qk_i == cdb_tag_i);
    assign snoop_j  = cdb_live && busy_q && (qj_q == cdb_tag_i);
    assign snoop_k  = cdb_live && busy_q && (qk_q == cdb_tag_i);

    always_comb begin
        busy_d  = busy_q;
        aluop_d = aluop_q;
        vj_d    = vj_q;
        qj_d    = qj_q;
        vk_d    = vk_q;
        qk_d    = qk_q;
        if (alloc_i) begin
            busy_d  = 1'b1;
            aluop_d = issue_aluop_i;
            vj_d    = bypass_j ? cdb_data_i : issue_vj_i;
            qj_d    = bypass_j ? '0 : issue_qj_i;
            vk_d    = bypass_k ? cdb_data_i : issue_vk_i;
            qk_d    = bypass_k ? '0 : issue_qk_i;
        end else begin
            if (clear_i) busy_d = 1'b0;
            if (snoop_j) begin
                vj_d = cdb_data_i;
                qj_d = '0;
            end
            if (snoop_k) begin
                vk_d = cdb_data_i;
                qk_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            aluop_q <= '0;
            vj_q    <= '0;
            qj_q    <= '0;
            vk_q    <= '0;
            qk_q    <= '0;
        end else begin
            busy_q  <= busy_d;
            aluop_q <= aluop_d;
            vj_q    <= vj_d;
            qj_q    <= qj_d;
            vk_q    <= vk_d;
            qk_q    <= qk_d;
        end
    end

    assign busy_o  = busy_q;
    assign ready_o = busy_q && (qj_q == '0) && (qk_q == '0);
    assign aluop_o = aluop_q;
    assign vj_o    = vj_q;
    assign vk_o    = vk_q;

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: lowest-free allocation and lowest-ready dispatch over rs_entry slots.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int ENTRIES = 3,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int RS_BASE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [1:0]        issue_aluop,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [TAG_W-1:0]  issue_qk,
    output logic [TAG_W-1:0]  issue_tag,
    output logic              is_full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              disp_valid,
    input  logic              disp_ready,
    output logic [1:0]        disp_aluop,
    output logic [DATA_W-1:0] disp_a,
    output logic [DATA_W-1:0] disp_b,
    output logic [TAG_W-1:0]  disp_tag
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0] busy, ready, alloc, clear;
    logic [1:0]         ent_aluop [ENTRIES];
    logic [DATA_W-1:0]  ent_vj [ENTRIES];
    logic [DATA_W-1:0]  ent_vk [ENTRIES];

    logic             free_found, ready_found, issue_accept, disp_fire;
    logic [IDX_W-1:0] free_idx, disp_idx;

    // Both selectors look at registered busy/ready only, so a slot freed this cycle is not reused until the next.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        ready_found = 1'b0;
        disp_idx    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!busy[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ready[i] && !ready_found) begin
                ready_found = 1'b1;
                disp_idx    = IDX_W'(i);
            end
        end
    end

    assign is_full      = &busy;
    assign issue_accept = issue_valid && !is_full;
    assign issue_tag    = TAG_W'(RS_BASE) + TAG_W'(free_idx);
    assign disp_valid   = ready_found;
    assign disp_fire    = disp_valid && disp_ready;
    assign disp_tag     = TAG_W'(RS_BASE) + TAG_W'(disp_idx);
    assign disp_aluop   = ent_aluop[disp_idx];
    assign disp_a       = ent_vj[disp_idx];
    assign disp_b       = ent_vk[disp_idx];

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        assign alloc[g] = issue_accept && (free_idx == IDX_W'(g));
        assign clear[g] = disp_fire && (disp_idx == IDX_W'(g));

        rs_entry #(
            .DATA_W (DATA_W),
            .TAG_W  (TAG_W)
        ) u_entry (
            .clk           (clk),
            .rst_n         (rst_n),
            .alloc_i       (alloc[g]),
            .clear_i       (clear[g]),
            .issue_aluop_i (issue_aluop),
            .issue_vj_i    (issue_vj),
            .issue_qj_i    (issue_qj),
            .issue_vk_i    (issue_vk),
            .issue_qk_i    (issue_qk),
            .cdb_valid_i   (cdb_valid),
            .cdb_tag_i     (cdb_tag),
            .cdb_data_i    (cdb_data),
            .busy_o        (busy[g]),
            .ready_o       (ready[g]),
            .aluop_o       (ent_aluop[g]),
            .vj_o          (ent_vj[g]),
            .vk_o          (ent_vk[g])
        );
    end

endmodule
